// File: rtl/sram_rw_port_ctrl.sv
// Request/response front end for port 0 (1RW) of an OpenRAM SRAM macro.
// Reads are credit-guarded so that every captured dout0 word has a FIFO slot.
module sram_rw_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_WMASKS = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  // Wide enough for fifo_count plus two in-flight reads without wrapping.
  localparam int CNT_W = $clog2(RSP_DEPTH + 3);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RBURST = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic                  rd_p1_q, rd_p1_d;
  logic                  rd_p2_q, rd_p2_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  req_ready_q, req_ready_d;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

  logic                  credit_ok_s, issue_rd_s, push_s, pop_s, rsp_valid_s;
  logic [CNT_W-1:0]      inflight_s, inflight_d_s;

  // Next-state logic for the issue FSM, read pipeline and response FIFO.
  always_comb begin
    state_d     = state_q;
    csb0_d      = 1'b1;
    web0_d      = 1'b1;
    wmask0_d    = wmask0_q;
    addr0_d     = addr0_q;
    din0_d      = din0_q;
    remaining_d = remaining_q;
    next_addr_d = next_addr_q;
    issue_rd_s  = 1'b0;
    inflight_s  = CNT_W'(rd_p1_q) + CNT_W'(rd_p2_q);
    credit_ok_s = (count_q + inflight_s) < CNT_W'(RSP_DEPTH);

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          csb0_d  = 1'b0;
          addr0_d = req_addr;
          if (req_we) begin
            web0_d   = 1'b0;
            din0_d   = req_wdata;
            wmask0_d = req_wmask;
          end else begin
            issue_rd_s  = 1'b1;
            remaining_d = req_len;
            next_addr_d = req_addr + ADDR_WIDTH'(1);
            state_d     = (req_len != {LEN_WIDTH{1'b0}}) ? S_RBURST : S_IDLE;
          end
        end else begin
          csb0_d = 1'b1;
        end
      end
      S_RBURST: begin
        if (credit_ok_s) begin
          csb0_d      = 1'b0;
          addr0_d     = next_addr_q;
          next_addr_d = next_addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          issue_rd_s  = 1'b1;
          state_d     = (remaining_q == LEN_WIDTH'(1)) ? S_IDLE : S_RBURST;
        end else begin
          csb0_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A read on the pins is sampled one edge later and captured the edge after.
    rd_p1_d      = issue_rd_s;
    rd_p2_d      = rd_p1_q;
    rsp_valid_s  = (count_q != {CNT_W{1'b0}});
    push_s       = rd_p2_q;
    pop_s        = rsp_valid_s && rsp_ready;
    wr_ptr_d     = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d     = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    inflight_d_s = CNT_W'(rd_p1_d) + CNT_W'(rd_p2_d);
    req_ready_d  = (state_d == S_IDLE) && ((count_d + inflight_d_s) < CNT_W'(RSP_DEPTH));
  end

  // State and pin registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      wmask0_q    <= {NUM_WMASKS{1'b0}};
      addr0_q     <= {ADDR_WIDTH{1'b0}};
      din0_q      <= {DATA_WIDTH{1'b0}};
      remaining_q <= {LEN_WIDTH{1'b0}};
      next_addr_q <= {ADDR_WIDTH{1'b0}};
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      wmask0_q    <= wmask0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      remaining_q <= remaining_d;
      next_addr_q <= next_addr_d;
      rd_p1_q     <= rd_p1_d;
      rd_p2_q     <= rd_p2_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Response storage; validity is tracked by count_q, so no clear is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_q] <= dout0;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_s;
  assign rsp_rdata = fifo_mem[rd_ptr_q];
  assign csb0      = csb0_q;
  assign web0      = web0_q;
  assign wmask0    = wmask0_q;
  assign addr0     = addr0_q;
  assign din0      = din0_q;

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Bench for sram_rw_port_ctrl: behavioural SRAM macro, request-level reference
// model with ordered pin/response queues, vector table, corner sequences, random traffic.
module tb_sram_rw_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = 10'h000;
  logic [7:0]  req_len = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wmask = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [9:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0 = 32'h0;

  int checks = 0;
  int failures = 0;
  int n_pops = 0;
  logic rdy_rand = 1'b0;
  logic rdy_man = 1'b0;
  logic sram_clear = 1'b1;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } op_t;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
  } vec_t;

  op_t         op_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [1024];
  logic [31:0] sram [1024];
  op_t         mon_op;
  logic [9:0]  mon_a;

  always #5 clk = ~clk;

  sram_rw_port_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM macro: samples pins on the edge, dout0 valid for one cycle then garbage.
  always @(posedge clk) begin
    if (sram_clear) begin
      for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
    end else if (!csb0 && !web0) begin
      sram[addr0] <= merge(sram[addr0], din0, wmask0);
    end
    if (!csb0 && web0) dout0 <= sram[addr0];
    else dout0 <= $urandom;
  end

  // Response-ready driver.
  always @(posedge clk) begin
    #2;
    rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_man;
  end

  // Reference model and in-order pin/response checker.
  always @(negedge clk) begin
    if (!rst_n) begin
      op_q.delete();
      exp_q.delete();
      if (sram_clear) for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    end else begin
      if (!csb0) begin
        if (op_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL pin_unexpected_op: got csb0=0 addr0=%h expected no access", addr0);
        end else begin
          mon_op = op_q.pop_front();
          chk("pin_web0", {31'h0, web0}, {31'h0, !mon_op.we});
          chk("pin_addr0", {22'h0, addr0}, {22'h0, mon_op.addr});
          if (mon_op.we) begin
            chk("pin_din0", din0, mon_op.wdata);
            chk("pin_wmask0", {28'h0, wmask0}, {28'h0, mon_op.wmask});
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected: got %h expected no response", rsp_rdata);
        end else begin
          chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
          op_q.push_back('{1'b1, req_addr, req_wdata, req_wmask});
        end else begin
          for (int i = 0; i <= int'(req_len); i++) begin
            mon_a = req_addr + 10'(i);
            op_q.push_back('{1'b0, mon_a, 32'h0, 4'h0});
            exp_q.push_back(ref_mem[mon_a]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [9:0] addr, input logic [7:0] len,
                        input logic [31:0] wd, input logic [3:0] wm);
    logic acc;
    int n;
    req_we = we; req_addr = addr; req_len = len; req_wdata = wd; req_wmask = wm;
    req_valid = 1'b1;
    n = 0;
    do begin
      acc = req_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    req_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL req_accept_timeout: got no ready in %0d cycles expected ready", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_rand = 1'b0;
    rdy_man = 1'b1;
    while ((exp_q.size() != 0 || op_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    chk("drain_outstanding", exp_q.size() + op_q.size(), 32'd0);
    rdy_man = 1'b0;
    tick();
  endtask

  vec_t vecs[9];

  initial begin
    int issues;
    int pops0;
    int nv;
    logic [9:0] ea;

    vecs[0] = '{1'b1, 10'h005, 32'hDEADBEEF, 4'b1111, 32'h0};
    vecs[1] = '{1'b1, 10'h005, 32'h11223344, 4'b0101, 32'h0};
    vecs[2] = '{1'b0, 10'h005, 32'h0, 4'b0000, 32'hDE22BE44};
    vecs[3] = '{1'b1, 10'h3FF, 32'hCAFEF00D, 4'b1111, 32'h0};
    vecs[4] = '{1'b0, 10'h3FF, 32'h0, 4'b0000, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 10'h3FF, 32'hA5000000, 4'b1000, 32'h0};
    vecs[6] = '{1'b0, 10'h3FF, 32'h0, 4'b0000, 32'hA5FEF00D};
    vecs[7] = '{1'b1, 10'h000, 32'h12345678, 4'b0011, 32'h0};
    vecs[8] = '{1'b0, 10'h000, 32'h0, 4'b0000, 32'h00005678};
    nv = 9;

    // Reset state
    tick(); tick();
    chk("rst_csb0", {31'h0, csb0}, 32'd1);
    chk("rst_web0", {31'h0, web0}, 32'd1);
    chk("rst_wmask0", {28'h0, wmask0}, 32'd0);
    chk("rst_addr0", {22'h0, addr0}, 32'd0);
    chk("rst_din0", din0, 32'd0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'd0);
    sram_clear = 1'b0;
    rst_n = 1'b1;
    tick(); tick();

    // Vector table: single-word ops with pin timing and read latency
    for (int i = 0; i < nv; i++) begin
      do_req(vecs[i].we, vecs[i].addr, 8'h00, vecs[i].wdata, vecs[i].wmask);
      chk("tbl_csb0", {31'h0, csb0}, 32'd0);
      chk("tbl_web0", {31'h0, web0}, {31'h0, !vecs[i].we});
      chk("tbl_addr0", {22'h0, addr0}, {22'h0, vecs[i].addr});
      if (vecs[i].we) begin
        chk("tbl_din0", din0, vecs[i].wdata);
        chk("tbl_wmask0", {28'h0, wmask0}, {28'h0, vecs[i].wmask});
      end
      tick();
      chk("tbl_idle_csb0", {31'h0, csb0}, 32'd1);
      if (!vecs[i].we) begin
        chk("tbl_lat1_valid", {31'h0, rsp_valid}, 32'd0);
        tick();
        chk("tbl_lat2_valid", {31'h0, rsp_valid}, 32'd1);
        chk("tbl_rdata", rsp_rdata, vecs[i].exp_rdata);
      end
      drain();
    end

    // Wrapping burst with rsp_ready high
    rdy_man = 1'b1;
    tick();
    do_req(1'b0, 10'h3FE, 8'd3, 32'h0, 4'h0);
    chk("burst_csb0_0", {31'h0, csb0}, 32'd0);
    chk("burst_addr0_0", {22'h0, addr0}, 32'h3FE);
    chk("burst_ready_0", {31'h0, req_ready}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      ea = 10'h3FE + 10'(i);
      chk("burst_csb0", {31'h0, csb0}, 32'd0);
      chk("burst_addr0", {22'h0, addr0}, {22'h0, ea});
      chk("burst_ready", {31'h0, req_ready}, (i == 3) ? 32'd1 : 32'd0);
    end
    drain();

    // Backpressure: credit stalls issue at RSP_DEPTH reads
    for (int i = 0; i < 8; i++) do_req(1'b1, 10'h100 + 10'(i), 8'h00, $urandom, 4'hF);
    drain();
    do_req(1'b0, 10'h100, 8'd7, 32'h0, 4'h0);
    issues = csb0 ? 0 : 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!csb0) issues++;
    end
    chk("bp_issued", issues, 32'd4);
    chk("bp_stall_csb0", {31'h0, csb0}, 32'd1);
    pops0 = n_pops;
    drain();
    chk("bp_returned", n_pops - pops0, 32'd8);

    // Capture and pop on the same edge
    do_req(1'b1, 10'h200, 8'h00, 32'h13579BDF, 4'hF);
    do_req(1'b1, 10'h201, 8'h00, 32'h2468ACE0, 4'hF);
    drain();
    do_req(1'b0, 10'h200, 8'd1, 32'h0, 4'h0);
    tick();
    tick();
    chk("pp_valid_a", {31'h0, rsp_valid}, 32'd1);
    chk("pp_rdata_a", rsp_rdata, 32'h13579BDF);
    rdy_man = 1'b1;
    tick();
    chk("pp_valid_b", {31'h0, rsp_valid}, 32'd1);
    chk("pp_rdata_b", rsp_rdata, 32'h2468ACE0);
    rdy_man = 1'b0;
    tick(); tick();
    chk("pp_hold_valid", {31'h0, rsp_valid}, 32'd1);
    chk("pp_hold_rdata", rsp_rdata, 32'h2468ACE0);
    rdy_man = 1'b1;
    tick();
    chk("pp_count_one", {31'h0, rsp_valid}, 32'd0);
    rdy_man = 1'b0;
    tick();

    // Reset in the middle of a burst with two reads in flight
    do_req(1'b0, 10'h300, 8'd7, 32'h0, 4'h0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_csb0", {31'h0, csb0}, 32'd1);
    chk("mrst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("mrst_req_ready", {31'h0, req_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("mrst_ready_after", {31'h0, req_ready}, 32'd1);
    issues = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) issues++;
    end
    chk("mrst_no_stale", issues, 32'd0);

    // Random traffic against the reference model
    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) ea = 10'h3FC + 10'($urandom_range(0, 3));
      else ea = 10'($urandom_range(0, 15));
      do_req(1'($urandom_range(0, 1)), ea, 8'($urandom_range(0, 5)), $urandom,
             4'($urandom_range(0, 15)));
      rdy_rand = 1'b1;
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    chk("final_exp_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_rw_port_ctrl.md
Name: sram_rw_port_ctrl

Overview:
- Initiator for the 1RW port (port 0) of the 32x1024 OpenRAM SRAM macro.
- Converts a valid/ready request stream (single writes with byte mask; single or burst reads) into the macro's active-low csb0/web0 pin protocol.
- Captures dout0 in the one-cycle window in which it is valid, and returns read data on a valid/ready response stream through a credit-guarded FIFO.
- Sits between the ConvHLS datapath and each SRAM instance.

Parameters:
- DATA_WIDTH, 32, SRAM word width.
- ADDR_WIDTH, 10, SRAM word-address width.
- NUM_WMASKS, 4, byte-lane count (DATA_WIDTH/8).
- LEN_WIDTH, 8, burst-length field width; a burst moves req_len+1 words.
- RSP_DEPTH, 4, response FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  single clock; also drives the SRAM clk0.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a clk edge when valid&&ready.
- req_we  in  1  1=write (single word), 0=read burst.
- req_addr  in  ADDR_WIDTH  start word address.
- req_len  in  LEN_WIDTH  read burst length-1; ignored for writes.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  NUM_WMASKS  byte enables, active high.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes data on a clk edge when valid&&ready.
- rsp_rdata  out  DATA_WIDTH  read data, in issue order.
- csb0  out  1  SRAM chip select, active low.
- web0  out  1  SRAM write enable, active low.
- wmask0  out  NUM_WMASKS  SRAM write mask.
- addr0  out  ADDR_WIDTH  SRAM address.
- din0  out  DATA_WIDTH  SRAM write data.
- dout0  in  DATA_WIDTH  SRAM read data.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
  - rsp_valid=0, req_ready=0.
  - FIFO emptied; in-flight and burst state cleared.
- Reset mid-operation: same as above, and it takes effect immediately. Pending reads are discarded and never returned. A partially issued burst is abandoned.
- SRAM pins are driven from flops only, so they are stable for a full cycle.
- An op launched at edge k is sampled by the SRAM at edge k+1. Read dout0 is captured into the FIFO at edge k+2 (before the SRAM drives X).
- Idle cycle: csb0=1, web0=1. The other pins hold their last value.
- FSM states:
  - IDLE:
    - req_ready = credit_ok.
    - Write accept: drive csb0=0, web0=0, addr0, din0, wmask0 next cycle. No credit needed. Stay in IDLE. Back-to-back writes at 1 per cycle.
    - Read accept: issue word 0 (csb0=0, web0=1, addr0=req_addr). Load remaining=req_len and next_addr=req_addr+1. Go to RBURST if req_len≠0, else stay in IDLE.
  - RBURST:
    - req_ready=0.
    - Each cycle with credit_ok, issue the next address and decrement remaining. Go to IDLE after the last word.
    - Without credit: insert an idle cycle (csb0=1).
- Credit: credit_ok = (fifo_count + inflight) < RSP_DEPTH, where inflight counts reads issued but not yet captured (0..2). This guarantees a capture never overflows the FIFO; dout0 is never held back.
- Address arithmetic is modulo 2^ADDR_WIDTH: addr 1023 +1 → 0.
- Response path:
  - rsp_valid = FIFO not empty; rsp_rdata = FIFO head.
  - A capture and a pop on the same edge both take effect; the count is unchanged.
  - With the FIFO empty, data is not bypassed; minimum read latency is 2 cycles from accept edge to rsp_valid=1 (3 edges).
- Throughput: with rsp_ready held high, sustained reads run at 1 word/cycle once RSP_DEPTH≥4.
- Ordering: responses are strictly in issue order. A write accepted after a read in IDLE follows it on the pins; there is no reordering.

Test Plan:
- Reset, then one write: addr=0x005, wdata=0xDEADBEEF, wmask=4'b1111 → next cycle csb0=0, web0=0, addr0=0x005, din0=0xDEADBEEF; then csb0=1.
- Masked write, then read: write 0x11223344 mask 4'b0101 over 0xDEADBEEF at 0x005; read 0x005 → rsp_rdata=0xDE22BE44, rsp_valid 2 cycles after accept.
- Burst read: addr=0x3FE, len=3, rsp_ready=1 → addr0 sequence 0x3FE, 0x3FF, 0x000, 0x001 on consecutive cycles; 4 responses in order; req_ready=0 until the last issue.
- Backpressure: burst len=7, rsp_ready=0 → exactly RSP_DEPTH reads issued, then csb0 stays 1. Raising rsp_ready resumes issue; all 8 words are returned in order with none lost.
- Simultaneous push and pop: FIFO holding 1 entry, capture and pop on the same edge → count stays at 1; rsp_rdata advances to the new word.
- Reset mid-burst: drop rst_n during RBURST with 2 reads in flight → csb0=1 and rsp_valid=0 immediately; after release req_ready=1 and no stale responses appear.
